// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multicycle MIPS subset core with internal instruction and data memories.
//   Instructions: add, sub, and, or, slt, lw, sw, beq, addi, j, jal, halt.
//   Unsupported opcodes or functs retire as NOPs.
//
// Optional feature macro: MIPS_MC_PERF_COUNT_EN
//   Defined   -> cycle_count and retire_count are live 32-bit wrapping counters.
//   Undefined -> both outputs are tied to 0 and no counter flops exist.
//
// Ports
//   clk, reset                   single clock, synchronous active-high reset
//   instr_write_*                instruction memory init write port
//   data_init_*                  data memory init write port (wins over a
//                                simultaneous sw to the same word)
//   dbg_reg_sel / dbg_reg_value  combinational register-file peek (r0 reads 0)
//   pc_out, state_out, halted    architectural PC, FSM state, HALT indicator
//   instr_retired                high during the final cycle of an instruction
//   cycle_count, retire_count    performance counters
module mips_multicycle_core #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          instr_write_enable,
    input  logic [$clog2(IMEM_DEPTH)-1:0] instr_write_addr,
    input  logic [31:0]                   instr_write_data,
    input  logic                          data_init_write_enable,
    input  logic [$clog2(DMEM_DEPTH)-1:0] data_init_addr,
    input  logic [31:0]                   data_init_data,
    input  logic [4:0]                    dbg_reg_sel,
    output logic [31:0]                   dbg_reg_value,
    output logic [31:0]                   pc_out,
    output logic [3:0]                    state_out,
    output logic                          instr_retired,
    output logic                          halted,
    output logic [31:0]                   cycle_count,
    output logic [31:0]                   retire_count
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_ADDI = 6'h08, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B, OP_HALT = 6'h3F;
    localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25, FN_SLT  = 6'h2A;

    state_t      state, next_state;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, alu_result, rf_rs, rf_rt;
    logic        funct_ok, retire_cond;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign rf_rs    = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rf_rt    = (rt == 5'd0) ? 32'd0 : regs[rt];

    assign dbg_reg_value = (dbg_reg_sel == 5'd0) ? 32'd0 : regs[dbg_reg_sel];
    assign pc_out        = pc;
    assign state_out     = state;
    assign halted        = (state == HALT);
    // An instruction cut short by reset never counts as retired.
    assign instr_retired = retire_cond & ~reset;

    // R-type ALU; funct_ok also decides whether an R-type is a NOP.
    always_comb begin
        funct_ok   = 1'b1;
        alu_result = '0;
        case (funct)
            FN_ADD:  alu_result = a + b;
            FN_SUB:  alu_result = a - b;
            FN_AND:  alu_result = a & b;
            FN_OR:   alu_result = a | b;
            FN_SLT:  alu_result = {31'd0, ($signed(a) < $signed(b))};
            default: funct_ok = 1'b0;
        endcase
    end

    // Next state and retire decode.
    always_comb begin
        next_state  = state;
        retire_cond = 1'b0;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = funct_ok ? EXEC : FETCH;
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J, OP_JAL: next_state = JUMP;
                    OP_HALT:      next_state = HALT;
                    default:      next_state = FETCH;
                endcase
                // NOPs and halt finish in DECODE.
                retire_cond = (next_state == FETCH) || (next_state == HALT);
            end
            MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXEC:   next_state = ALUWB;
            ADDIEX: next_state = ADDIWB;
            MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: begin
                next_state  = FETCH;
                retire_cond = 1'b1;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // Register-file write port selection.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state)
            MEMWB:  begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = mdr;     end
            ALUWB:  begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = alu_out; end
            ADDIWB: begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = alu_out; end
            // pc already points past the jal here.
            JUMP:   begin rf_we = (opcode == OP_JAL); rf_waddr = 5'd31; rf_wdata = pc; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir <= imem[pc[IAW+1:2]];
                    pc <= pc + 32'd4;
                end
                DECODE: begin
                    a       <= rf_rs;
                    b       <= rf_rt;
                    alu_out <= pc + {imm_sext[29:0], 2'b00};
                end
                MEMADR, ADDIEX: alu_out <= a + imm_sext;
                MEMRD:          mdr     <= dmem[alu_out[DAW+1:2]];
                EXEC:           alu_out <= alu_result;
                BRANCH:         if (a == b) pc <= alu_out;
                JUMP:           pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Memories are never cleared. The init write is placed after the sw so
    // it wins when both hit the same word on the same edge.
    always_ff @(posedge clk) begin
        if (instr_write_enable) imem[instr_write_addr] <= instr_write_data;
        if (!reset && (state == MEMWR)) dmem[alu_out[DAW+1:2]] <= b;
        if (data_init_write_enable) dmem[data_init_addr] <= data_init_data;
    end

`ifdef MIPS_MC_PERF_COUNT_EN
    logic [31:0] cycle_q, retire_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if (state != HALT) cycle_q  <= cycle_q + 32'd1;
            if (instr_retired) retire_q <= retire_q + 32'd1;
        end
    end
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
`else
    assign cycle_count  = 32'd0;
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core
//   Directed programs plus randomized programs, each checked against an
//   instruction-level reference model of the ISA held in this module.
module tb_mips_multicycle_core;
    localparam int          IAW      = 8;
    localparam int          DAW      = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HALT_W   = 32'hFC00_0000;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic            instr_write_enable;
    logic [IAW-1:0]  instr_write_addr;
    logic [31:0]     instr_write_data;
    logic            data_init_write_enable;
    logic [DAW-1:0]  data_init_addr;
    logic [31:0]     data_init_data;
    logic [4:0]      dbg_reg_sel;
    logic [31:0]     dbg_reg_value, pc_out, cycle_count, retire_count;
    logic [3:0]      state_out;
    logic            instr_retired, halted;

    always #50 clk = ~clk;

    mips_multicycle_core #(
        .IMEM_DEPTH(256), .DMEM_DEPTH(256), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .instr_write_enable(instr_write_enable), .instr_write_addr(instr_write_addr),
        .instr_write_data(instr_write_data),
        .data_init_write_enable(data_init_write_enable), .data_init_addr(data_init_addr),
        .data_init_data(data_init_data),
        .dbg_reg_sel(dbg_reg_sel), .dbg_reg_value(dbg_reg_value),
        .pc_out(pc_out), .state_out(state_out), .instr_retired(instr_retired),
        .halted(halted), .cycle_count(cycle_count), .retire_count(retire_count)
    );

    initial begin
        #(100 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_imem [256];
    logic [31:0] m_dmem [256];
    logic [31:0] m_reg  [32];
    logic [31:0] m_pc, m_cycles, m_retired;
    bit          m_halted;
    logic [31:0] prog_q [$];
    logic [31:0] hist_pc [64];
    int          hist_cyc [64];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_pc = RESET_PC; m_halted = 0; m_cycles = '0; m_retired = '0;
    endtask

    // Executes one whole instruction; returns its expected cycle count.
    task automatic model_step(output int cyc);
        logic [31:0] ins, npc, ra, rb, sx, addr, res;
        logic [4:0]  wa;
        bit          wr;
        ins = m_imem[m_pc[IAW+1:2]];
        ra  = m_reg[ins[25:21]];
        rb  = m_reg[ins[20:16]];
        sx  = {{16{ins[15]}}, ins[15:0]};
        npc = m_pc + 32'd4;
        m_pc = npc;
        wr = 0; wa = '0; res = '0; cyc = 2;
        case (ins[31:26])
            6'h00: begin
                cyc = 4; wr = 1; wa = ins[15:11];
                case (ins[5:0])
                    6'h20: res = ra + rb;
                    6'h22: res = ra - rb;
                    6'h24: res = ra & rb;
                    6'h25: res = ra | rb;
                    6'h2A: res = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
                    default: begin cyc = 2; wr = 0; end
                endcase
            end
            6'h23: begin addr = ra + sx; wr = 1; wa = ins[20:16]; res = m_dmem[addr[DAW+1:2]]; cyc = 5; end
            6'h2B: begin addr = ra + sx; m_dmem[addr[DAW+1:2]] = rb; cyc = 4; end
            6'h04: begin if (ra == rb) m_pc = npc + (sx << 2); cyc = 3; end
            6'h08: begin wr = 1; wa = ins[20:16]; res = ra + sx; cyc = 4; end
            6'h02: begin m_pc = {npc[31:28], ins[25:0], 2'b00}; cyc = 3; end
            6'h03: begin m_pc = {npc[31:28], ins[25:0], 2'b00}; wr = 1; wa = 5'd31; res = npc; cyc = 3; end
            6'h3F: begin m_halted = 1; cyc = 2; end
            default: cyc = 2;
        endcase
        if (wr && (wa != 5'd0)) m_reg[wa] = res;
        m_cycles  = m_cycles + 32'(cyc);
        m_retired = m_retired + 32'd1;
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd_, input logic [4:0] rs_, input logic [4:0] rt_);
        return {6'h00, rs_, rt_, rd_, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs_, input logic [4:0] rt_, input logic [15:0] imm);
        return {op, rs_, rt_, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic load_prog(input int count);
        logic [31:0] w;
        for (int i = 0; i < count; i++) begin
            w = (i < prog_q.size()) ? prog_q[i] : HALT_W;
            instr_write_enable = 1'b1;
            instr_write_addr   = i[IAW-1:0];
            instr_write_data   = w;
            m_imem[i]          = w;
            @(negedge clk);
        end
        instr_write_enable = 1'b0;
    endtask

    task automatic dmem_write(input int idx, input logic [31:0] val);
        data_init_write_enable = 1'b1;
        data_init_addr         = idx[DAW-1:0];
        data_init_data         = val;
        m_dmem[idx]            = val;
        @(negedge clk);
        data_init_write_enable = 1'b0;
    endtask

    task automatic get_reg(input int idx, output logic [31:0] v);
        dbg_reg_sel = idx[4:0];
        #1;
        v = dbg_reg_value;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        check({tag, "_pc"}, pc_out, m_pc);
        check({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
`ifdef MIPS_MC_PERF_COUNT_EN
        check({tag, "_cycle_count"}, cycle_count, m_cycles);
        check({tag, "_retire_count"}, retire_count, m_retired);
`else
        check({tag, "_cycle_count"}, cycle_count, 32'd0);
        check({tag, "_retire_count"}, retire_count, 32'd0);
`endif
        for (int i = 0; i < 32; i++) begin
            get_reg(i, v);
            check($sformatf("%s_r%0d", tag, i), v, m_reg[i]);
        end
    endtask

    // Runs one DUT instruction starting at its FETCH cycle; ends at the
    // negedge of the following instruction's first cycle.
    task automatic run_dut_instr(output int cyc, output bit ok);
        cyc = 0; ok = 0;
        for (int k = 0; k < 16; k++) begin
            cyc++;
            if (instr_retired) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // Reset, load prog_q, then step DUT and model in lockstep until halt.
    task automatic run_program(input string tag, input int max_instr);
        int  ecyc, gcyc;
        bit  ok;
        reset = 1'b1;
        load_prog(32);
        model_reset();
        check({tag, "_rst_state"}, {28'd0, state_out}, 32'd0);
        check({tag, "_rst_retired"}, {31'd0, instr_retired}, 32'd0);
        check_all({tag, "_rst"});
        reset = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            model_step(ecyc);
            run_dut_instr(gcyc, ok);
            if (!ok) begin
                check($sformatf("%s_timeout_i%0d", tag, n), 32'd0, 32'd1);
                return;
            end
            hist_pc[n]  = pc_out;
            hist_cyc[n] = gcyc;
            check($sformatf("%s_cycles_i%0d", tag, n), 32'(gcyc), 32'(ecyc));
            check_all($sformatf("%s_i%0d", tag, n));
            if (m_halted) break;
        end
        if (m_halted) begin
            repeat (5) @(negedge clk);
            check({tag, "_halt_state"}, {28'd0, state_out}, 32'd12);
            check_all({tag, "_frozen"});
        end
    endtask

    // Start prog_q, reset once the FSM reaches stop_state, check the abort.
    task automatic run_abort(input string tag, input logic [3:0] stop_state);
        bit found;
        reset = 1'b1;
        load_prog(32);
        reset = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (state_out == stop_state) begin found = 1; break; end
            @(negedge clk);
        end
        check({tag, "_reached"}, {31'd0, found}, 32'd1);
        reset = 1'b1;
        #1;
        check({tag, "_retired_gated"}, {31'd0, instr_retired}, 32'd0);
        @(negedge clk);
        model_reset();
        check({tag, "_state"}, {28'd0, state_out}, 32'd0);
        check_all(tag);
    endtask

    task automatic gen_random_prog(input int n);
        int          k, off;
        logic [4:0]  r1, r2, r3;
        logic [5:0]  fns [6];
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
        fns[3] = 6'h25; fns[4] = 6'h2A; fns[5] = 6'h21;
        prog_q.delete();
        for (int i = 0; i < n; i++) begin
            k   = $urandom_range(0, 10);
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            r3  = 5'($urandom_range(0, 7));
            off = $urandom_range(0, 3);
            case (k)
                0, 1:    prog_q.push_back(enc_i(6'h08, r1, r2, 16'($urandom)));
                2, 3, 4: prog_q.push_back(enc_r(fns[$urandom_range(0, 5)], r3, r1, r2));
                5:       prog_q.push_back(enc_i(6'h23, r1, r2, 16'($urandom_range(0, 63) * 4)));
                6:       prog_q.push_back(enc_i(6'h2B, r1, r2, 16'($urandom_range(0, 63) * 4)));
                7:       prog_q.push_back(enc_i(6'h04, r1, r2, 16'(off)));
                8:       prog_q.push_back(enc_i(6'h0D, r1, r2, 16'($urandom)));
                9:       prog_q.push_back(enc_i(6'h08, r1, 5'd0, 16'($urandom)));
                default: prog_q.push_back(enc_j(6'h02, 26'(i + 1 + off)));
            endcase
        end
        prog_q.push_back(HALT_W);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] v;

    initial begin
        reset = 1'b1;
        instr_write_enable = 1'b0; instr_write_addr = '0; instr_write_data = '0;
        data_init_write_enable = 1'b0; data_init_addr = '0; data_init_data = '0;
        dbg_reg_sel = '0;
        repeat (2) @(negedge clk);

        prog_q.delete();
        load_prog(256);
        for (int i = 0; i < 256; i++) dmem_write(i, $urandom);

        // arithmetic chain
        prog_q.delete();
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        prog_q.push_back(enc_r(6'h20, 5'd3, 5'd1, 5'd2));
        prog_q.push_back(HALT_W);
        run_program("arith", 8);
        get_reg(3, v); check("arith_r3", v, 32'd12);
`ifdef MIPS_MC_PERF_COUNT_EN
        check("arith_cycles_total", 32'(hist_cyc[0] + hist_cyc[1] + hist_cyc[2]), 32'd12);
`endif

        // slt / sub / logic / wrap / NOPs
        prog_q.delete();
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd6, 16'hFFFF));
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd7, 16'd1));
        prog_q.push_back(enc_r(6'h2A, 5'd5, 5'd6, 5'd7));
        prog_q.push_back(enc_r(6'h22, 5'd8, 5'd0, 5'd7));
        prog_q.push_back(enc_r(6'h24, 5'd9, 5'd6, 5'd7));
        prog_q.push_back(enc_r(6'h25, 5'd10, 5'd6, 5'd7));
        prog_q.push_back(enc_r(6'h2A, 5'd11, 5'd7, 5'd6));
        prog_q.push_back(enc_r(6'h20, 5'd12, 5'd6, 5'd7));
        prog_q.push_back(enc_r(6'h21, 5'd13, 5'd6, 5'd7));
        prog_q.push_back(enc_i(6'h0D, 5'd6, 5'd14, 16'h1234));
        prog_q.push_back(HALT_W);
        run_program("alu", 16);
        get_reg(5, v);  check("slt_neg_lt_pos", v, 32'd1);
        get_reg(8, v);  check("sub_0_minus_1", v, 32'hFFFF_FFFF);
        get_reg(11, v); check("slt_pos_lt_neg", v, 32'd0);
        get_reg(12, v); check("add_wrap", v, 32'd0);
        check("nop_cycles", 32'(hist_cyc[8]), 32'd2);

        // load / store
        dmem_write(4, 32'hDEAD_BEEF);
        prog_q.delete();
        prog_q.push_back(enc_i(6'h23, 5'd0, 5'd4, 16'd16));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd4, 16'd20));
        prog_q.push_back(enc_i(6'h23, 5'd0, 5'd9, 16'd20));
        prog_q.push_back(HALT_W);
        run_program("mem", 8);
        get_reg(4, v); check("lw_r4", v, 32'hDEAD_BEEF);
        get_reg(9, v); check("sw_dmem5", v, 32'hDEAD_BEEF);
        check("lw_cycles", 32'(hist_cyc[0]), 32'd5);
        check("sw_cycles", 32'(hist_cyc[1]), 32'd4);

        // beq taken / not taken
        for (int t = 0; t < 2; t++) begin
            prog_q.delete();
            prog_q.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd3));
            prog_q.push_back(enc_i(6'h08, 5'd0, 5'd2, (t == 0) ? 16'd3 : 16'd4));
            prog_q.push_back(enc_i(6'h04, 5'd1, 5'd2, 16'd2));
            prog_q.push_back(enc_i(6'h08, 5'd0, 5'd10, 16'd1));
            prog_q.push_back(enc_i(6'h08, 5'd0, 5'd11, 16'd2));
            prog_q.push_back(HALT_W);
            run_program((t == 0) ? "beq_t" : "beq_nt", 8);
            check((t == 0) ? "beq_taken_pc" : "beq_not_taken_pc", hist_pc[2], (t == 0) ? 32'd20 : 32'd12);
            check("beq_cycles", 32'(hist_cyc[2]), 32'd3);
        end

        // j / jal / write to r0
        prog_q.delete();
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd9));
        prog_q.push_back(enc_j(6'h02, 26'd8));
        for (int i = 2; i < 8; i++) prog_q.push_back(HALT_W);
        prog_q.push_back(enc_j(6'h03, 26'h10));
        for (int i = 9; i < 16; i++) prog_q.push_back(HALT_W);
        prog_q.push_back(enc_r(6'h20, 5'd0, 5'd1, 5'd1));
        prog_q.push_back(HALT_W);
        run_program("jump", 8);
        check("jal_pc", hist_pc[2], 32'h40);
        get_reg(31, v); check("jal_r31", v, 32'h24);
        get_reg(0, v);  check("r0_stays_0", v, 32'd0);

        // reset during lw writeback and during sw
        prog_q.delete();
        prog_q.push_back(enc_i(6'h23, 5'd0, 5'd4, 16'd16));
        prog_q.push_back(HALT_W);
        run_abort("abort_lw", 4'd4);
        prog_q.delete();
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'h55));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd1, 16'd40));
        prog_q.push_back(HALT_W);
        run_abort("abort_sw", 4'd5);
        prog_q.delete();
        prog_q.push_back(enc_i(6'h23, 5'd0, 5'd2, 16'd40));
        prog_q.push_back(HALT_W);
        run_program("after_abort", 4);

        // randomized programs
        for (int p = 0; p < 6; p++) begin
            gen_random_prog(24);
            run_program($sformatf("rand%0d", p), 64);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
